// File: rtl/eq_serial_ctrl_pkg.sv
// Shared types and helpers for the serial equality controller.
// The state encoding is fixed at 2 bits so it is visible on a debug bus.
package eq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of the bit index and counter. It never drops below 1 bit.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/eq_serial_ctrl_if.sv
// Request/result bundle between a requester and eq_serial_ctrl.
// The requester uses the master modport and the controller uses the slave modport.
interface eq_serial_ctrl_if
  import eq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_w(WIDTH)
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic [IDX_W-1:0] mismatch_idx;

  modport master (
    output start, a, b,
    input  busy, done, eq, mismatch_idx
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, mismatch_idx
  );

endinterface

// File: rtl/eq_serial_ctrl_eq1.sv
// One-bit equality cell. The controller time-shares it across all operand bits.
module eq1 (
  input  logic i0,
  input  logic i1,
  output logic eq
);

  assign eq = ~(i0 ^ i1);

endmodule

// File: rtl/eq_serial_ctrl.sv
// Serial N-bit equality sequencer. It streams operand bits LSB first through a single eq1 cell.
// Define EQ_SERIAL_EARLY_EXIT_EN to finish on the first mismatching bit instead of scanning all bits.
module eq_serial_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  eq_serial_ctrl_if.slave  bus
);

  localparam int               IDX_W    = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] mm_q, mm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             acc_q, acc_d;
  logic             found_q, found_d;
  logic             eq_q, eq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             eq_bit;
  logic             miss_first;
  logic             last_bit;
  logic             finish;

  eq1 u_eq1 (
    .i0 (sa_q[0]),
    .i1 (sb_q[0]),
    .eq (eq_bit)
  );

  assign miss_first = (state_q == S_RUN) && !eq_bit && !found_q;
  assign last_bit   = (cnt_q == LAST_IDX);

`ifdef EQ_SERIAL_EARLY_EXIT_EN
  assign finish = last_bit || miss_first;
`else
  assign finish = last_bit;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    mm_d    = mm_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    found_d = found_q;
    eq_d    = eq_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = '0;
          mm_d    = '0;
          acc_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d = acc_q & eq_bit;
        if (miss_first) begin
          mm_d    = cnt_q;
          found_d = 1'b1;
        end
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        // Hold at the last index so the counter can never wrap.
        if (!last_bit) cnt_d = cnt_q + IDX_W'(1);
        // Publish results from the post-update values so the final bit is included.
        if (finish) begin
          state_d = S_DONE;
          eq_d    = acc_d;
          idx_d   = acc_d ? {IDX_W{1'b0}} : mm_d;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      mm_q    <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      found_q <= 1'b0;
      eq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      mm_q    <= mm_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      found_q <= found_d;
      eq_q    <= eq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.eq           = eq_q;
  assign bus.mismatch_idx = idx_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Randomised self-checking bench for eq_serial_ctrl at WIDTH=8 and at WIDTH=1.
// Expected results come from integer comparison of the operands and from the documented latency rule.
module tb_eq_serial_ctrl;
  import eq_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int IW = idx_w(W);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_serial_ctrl_if #(.WIDTH(W)) bus8 ();
  eq_serial_ctrl_if #(.WIDTH(1)) bus1 ();

  eq_serial_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  eq_serial_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;
  logic          prev_eq  = 1'b0;
  logic [IW-1:0] prev_idx = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: find the lowest differing bit, or return -1 when the operands are equal.
  function automatic int first_diff(input logic [63:0] x, input logic [63:0] y, input int w);
    for (int i = 0; i < w; i++) if (x[i] != y[i]) return i;
    return -1;
  endfunction

  // Reference model: number of clock edges after the start edge until done is visible.
  function automatic int exp_lat(input int idx, input int w);
`ifdef EQ_SERIAL_EARLY_EXIT_EN
    return (idx < 0) ? w : idx + 1;
`else
    return w;
`endif
  endfunction

  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int  idx, lat, k;
    bit  seen;
    logic          e_eq;
    logic [IW-1:0] e_idx;
    idx   = first_diff(64'(a), 64'(b), W);
    lat   = exp_lat(idx, W);
    e_eq  = (a == b);
    e_idx = (idx < 0) ? '0 : IW'(idx);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    check("busy_after_start", 64'(bus8.busy), 64'd1);
    if (!hold) bus8.start = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < W + 4) begin
      // With hold set, change the operands every cycle; the result must still use the values captured at start.
      if (hold) begin bus8.a = W'($urandom); bus8.b = W'($urandom); end
      @(posedge clk); #1; k++;
      if (bus8.done) seen = 1'b1;
      else check("result_stable_in_run", 64'({bus8.eq, bus8.mismatch_idx}), 64'({prev_eq, prev_idx}));
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(k), 64'(lat));
    check("eq", 64'(bus8.eq), 64'(e_eq));
    check("mismatch_idx", 64'(bus8.mismatch_idx), 64'(e_idx));
    prev_eq = e_eq; prev_idx = e_idx;
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus8.done), 64'd0);
    check("idle_after_done", 64'(bus8.busy), 64'd0);
    $display("op w=8 a=%h b=%h hold=%0d -> eq=%0d idx=%0d lat=%0d", a, b, hold, bus8.eq, bus8.mismatch_idx, k);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;

    #12;
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_eq", 64'(bus8.eq), 64'd0);
    check("rst_idx", 64'(bus8.mismatch_idx), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    op8(8'hA5, 8'hA5, 1'b0);
    op8(8'h80, 8'h00, 1'b0);
    op8(8'hA5, 8'hA4, 1'b0);
    op8(W'($urandom), W'($urandom), 1'b1);
    op8(8'h3C, 8'h3C, 1'b0);
    op8(8'h80, 8'h00, 1'b0);

    // Apply an asynchronous reset in the middle of RUN.
    @(negedge clk); bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h5A;
    @(posedge clk); #1; bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    check("async_rst_busy", 64'(bus8.busy), 64'd0);
    check("async_rst_done", 64'(bus8.done), 64'd0);
    check("async_rst_eq", 64'(bus8.eq), 64'd0);
    check("async_rst_idx", 64'(bus8.mismatch_idx), 64'd0);
    prev_eq = 1'b0; prev_idx = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_done_in_reset", 64'(bus8.done), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("op w=8 reset mid-run applied");
    op8(8'hC3, 8'hC3, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      op8(ra, rb, 1'($urandom_range(0, 1)));
    end

    // WIDTH=1: try all four operand pairs.
    for (int p = 0; p < 4; p++) begin
      int  k;
      bit  seen;
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = 1'(p >> 1); bus1.b = 1'(p);
      @(posedge clk); #1; bus1.start = 1'b0;
      seen = 1'b0; k = 0;
      while (!seen && k < 5) begin
        @(posedge clk); #1; k++;
        if (bus1.done) seen = 1'b1;
      end
      check("w1_done_seen", 64'(seen), 64'd1);
      check("w1_latency", 64'(k), 64'd1);
      check("w1_eq", 64'(bus1.eq), 64'((p == 0) || (p == 3)));
      check("w1_idx", 64'(bus1.mismatch_idx), 64'd0);
      $display("op w=1 a=%0d b=%0d -> eq=%0d lat=%0d", p >> 1, p & 1, bus1.eq, k);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
